// File: rtl/axi_xbar_pkg.sv
// Shared AXI crossbar widths plus the requester-pick helper used by the AW arbiter.
package axi_xbar_pkg;

    localparam int unsigned AW_ADDR_W  = 14;
    localparam int unsigned AW_LEN_W   = 8;
    localparam int unsigned AW_SIZE_W  = 3;
    localparam int unsigned AW_BURST_W = 2;
    localparam int unsigned AW_ID_W    = 6;
    localparam int unsigned NUM_MST    = 4;
    localparam int unsigned IDX_W      = 2;

    typedef logic [IDX_W-1:0] idx_t;

    // First valid requester at or after ptr, scanning modulo NUM_MST; ptr=0 gives fixed priority.
    function automatic idx_t rr_pick(input logic [NUM_MST-1:0] valid, input idx_t ptr);
        idx_t idx;
        logic found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < NUM_MST; i++) begin
            idx = ptr + IDX_W'(i);
            if (!found && valid[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/streamfifo.sv
// Small synchronous FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module streamfifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + CntW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: contents are only observed while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/write_address_arbiter.sv
// AW arbiter for NUM_MST requesters with a W-order queue telling the W mux whom to route next.
// Define WAA_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead of round-robin.
module write_address_arbiter
    import axi_xbar_pkg::*;
#(
    parameter int unsigned ORDER_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_MST-1:0][AW_ADDR_W-1:0]   s_aw_addr,
    input  logic [NUM_MST-1:0][AW_LEN_W-1:0]    s_aw_awlen,
    input  logic [NUM_MST-1:0][AW_SIZE_W-1:0]   s_aw_awsize,
    input  logic [NUM_MST-1:0][AW_BURST_W-1:0]  s_aw_awburst,
    input  logic [NUM_MST-1:0][AW_ID_W-1:0]     s_aw_awid,
    input  logic [NUM_MST-1:0]                  s_aw_valid,
    output logic [NUM_MST-1:0]                  s_aw_ready,
    output logic [AW_ADDR_W-1:0]                m_axi_aw_addr,
    output logic [AW_LEN_W-1:0]                 m_axi_aw_awlen,
    output logic [AW_SIZE_W-1:0]                m_axi_aw_awsize,
    output logic [AW_BURST_W-1:0]               m_axi_aw_awburst,
    output logic [AW_ID_W-1:0]                  m_axi_aw_awid,
    output logic                                m_axi_aw_valid,
    input  logic                                m_axi_aw_ready,
    output logic [IDX_W-1:0]                    w_order_idx,
    output logic                                w_order_valid,
    input  logic                                w_last_fire
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StGrant = 1'b1;

    logic [0:0] state_q, state_d;
    idx_t       grant_idx_q, grant_idx_d;
    idx_t       winner;
    idx_t       fifo_head;
    logic       fifo_full, fifo_empty;
    logic       push;

`ifdef WAA_FIXED_PRIORITY_EN
    assign winner = rr_pick(s_aw_valid, IDX_W'(0));
`else
    idx_t rr_ptr_q, rr_ptr_d;

    assign winner = rr_pick(s_aw_valid, rr_ptr_q);

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = grant_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Fullness is sampled only in IDLE, so a grant already issued always has a free slot.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        push        = 1'b0;
        case (state_q)
            StIdle: begin
                if (|s_aw_valid && !fifo_full) begin
                    grant_idx_d = winner;
                    state_d     = StGrant;
                end
            end
            default: begin
                if (m_axi_aw_ready) begin
                    push    = 1'b1;
                    state_d = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    always_comb begin
        s_aw_ready       = '0;
        m_axi_aw_valid   = 1'b0;
        m_axi_aw_addr    = '0;
        m_axi_aw_awlen   = '0;
        m_axi_aw_awsize  = '0;
        m_axi_aw_awburst = '0;
        m_axi_aw_awid    = '0;
        if (state_q == StGrant) begin
            m_axi_aw_valid          = 1'b1;
            m_axi_aw_addr           = s_aw_addr[grant_idx_q];
            m_axi_aw_awlen          = s_aw_awlen[grant_idx_q];
            m_axi_aw_awsize         = s_aw_awsize[grant_idx_q];
            m_axi_aw_awburst        = s_aw_awburst[grant_idx_q];
            m_axi_aw_awid           = s_aw_awid[grant_idx_q];
            s_aw_ready[grant_idx_q] = m_axi_aw_ready;
        end
    end

    streamfifo #(
        .WIDTH (IDX_W),
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (grant_idx_q),
        .pop_i   (w_last_fire),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign w_order_valid = !fifo_empty;
    assign w_order_idx   = fifo_empty ? '0 : fifo_head;

endmodule

// File: doc/write_address_arbiter.md
WRITE_ADDRESS_ARBITER -- requirements
Module: write_address_arbiter

Interface
REQ-001 SHALL have parameter ORDER_DEPTH, default 4, meaning the depth of the W-order queue (power of 2, ≥2).
REQ-002 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port s_aw_addr  input  4x14  per-requester AW address, one requester per write_address_decoder.
REQ-005 SHALL have ports s_aw_awlen/awsize/awburst/awid  input  4x8/4x3/4x2/4x6  per-requester AW fields; awid already carries the {index, id} tag.
REQ-006 SHALL have ports s_aw_valid  input  4 and s_aw_ready  output  4  per-requester handshake.
REQ-007 SHALL have ports m_axi_aw_addr/awlen/awsize/awburst/awid  output  14/8/3/2/6, m_axi_aw_valid  output  1, m_axi_aw_ready  input  1  slave AW channel.
REQ-008 SHALL have ports w_order_idx  output  2, w_order_valid  output  1  the requester whose W burst the W mux must route next.
REQ-009 SHALL have port w_last_fire  input  1  W beat with wlast accepted by the slave.

Function
REQ-010 SHALL run FSM states IDLE and GRANT; reset state IDLE.
REQ-011 IDLE: if any s_aw_valid and order queue not full, SHALL latch the winner in grant_idx and go to GRANT; otherwise stay IDLE.
REQ-012 Winner SHALL be round-robin: first valid requester at or after rr_ptr, scanning modulo 4; rr_ptr resets to 0.
REQ-013 GRANT: m_axi_aw_valid=1, m_axi_aw_* SHALL equal the latched grant_idx requester's fields, and s_aw_ready[grant_idx]=m_axi_aw_ready, with all other s_aw_ready bits 0.
REQ-014 On m_axi_aw_valid&&m_axi_aw_ready SHALL push grant_idx into the order queue, set rr_ptr=grant_idx+1 (2-bit wrap 3→0), and return to IDLE, giving 1 idle cycle between grants.
REQ-015 A grant SHALL be held until its handshake completes; neither the requester nor the payload may change while in GRANT.
REQ-016 w_order_valid SHALL be order-queue not-empty, and w_order_idx SHALL be the queue head; w_last_fire with a non-empty queue SHALL pop; w_last_fire with an empty queue SHALL be ignored.
REQ-017 Simultaneous push and pop SHALL both take effect, and the occupancy SHALL be unchanged.
REQ-018 Queue full (ORDER_DEPTH entries) SHALL block new grants; an in-progress GRANT is never full-blocked because fullness is checked at IDLE.
REQ-019 All outputs SHALL be registered or decoded from registered state, with no combinational path from s_aw_valid to m_axi_aw_valid.

Reset
REQ-020 On rst_n=0 SHALL force state=IDLE, grant_idx=0, rr_ptr=0, and an empty queue, with m_axi_aw_valid=0, s_aw_ready=0, w_order_valid=0, w_order_idx=0, and m_axi_aw_* fields=0.
REQ-021 Reset mid-GRANT or with a non-empty queue SHALL discard all pending state without emitting a handshake.

Configuration
REQ-022 Macro WAA_FIXED_PRIORITY_EN: when defined, the winner SHALL be the lowest-index valid requester, and rr_ptr SHALL be removed.
REQ-023 When WAA_FIXED_PRIORITY_EN is undefined, round-robin per REQ-012 SHALL apply.

Structure
REQ-024 Shared package axi_xbar_pkg SHALL hold AW_ADDR_W=14, AW_LEN_W=8, AW_ID_W=6, and NUM_MST=4.
REQ-025 The order queue SHALL instantiate the existing streamfifo (WIDTH=2, DEPTH=ORDER_DEPTH), and there SHALL be no other sub-module.

Verification
REQ-026 Requester 2 alone, addr=0x0100, len=3, m_aw_ready=1 -> m_aw_valid on cycle 2 with addr 0x0100, then w_order_idx=2 and w_order_valid=1.
REQ-027 All 4 valid continuously with ready=1 -> grant order 0,1,2,3,0 (with the macro defined: 0,0,0…).
REQ-028 m_aw_ready held low 5 cycles in GRANT -> payload and grant_idx stable, only s_aw_ready[grant] tracks ready, and the handshake completes on the first ready cycle.
REQ-029 ORDER_DEPTH=4, 4 grants with no w_last_fire -> the 5th requester stays unserved; one w_last_fire -> next grant issued, and w_order_idx advances to the second-granted index.
REQ-030 push and w_last_fire in the same cycle with 2 entries -> occupancy stays 2; w_last_fire on an empty queue -> no change.
REQ-031 rst_n low mid-GRANT with 3 queued -> all outputs 0 the same cycle, and after release the first grant goes to requester 0.
